instruction_buffer: RTL and testbench

- Decoupling FIFO between the instruction fetcher and the decode stage.
- Accepts up to two 32-bit instructions plus addresses per cycle from the fetcher and presents up to two to decode per cycle in program order.
- Back-pressures the fetcher with `stall`; cleared by `flush` on a taken branch.

---
 rtl/instruction_buffer.sv | 134 +++++++++++++
 tb/tb_instruction_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_buffer.sv
// Two-in / two-out instruction FIFO between fetch and decode, cleared on flush.
// Optional macro IBUF_BYPASS_EN lets an empty buffer forward incoming instructions same-cycle.
module instruction_buffer #(
   parameter int DEPTH = 8,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [XLEN-1:0]          instructionA,
   input  logic [XLEN-1:0]          instructionB,
   input  logic [XLEN-1:0]          addressA,
   input  logic [XLEN-1:0]          addressB,
   input  logic                     instructionA_valid,
   input  logic                     instructionB_valid,
   output logic                     stall,
   output logic [XLEN-1:0]          issueA,
   output logic [XLEN-1:0]          issueB,
   output logic [XLEN-1:0]          issueAddressA,
   output logic [XLEN-1:0]          issueAddressB,
   output logic                     issueA_valid,
   output logic                     issueB_valid,
   input  logic [1:0]               consume,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] addr_mem  [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic [1:0]    enq;
   logic [1:0]    deq;
   logic [1:0]    consume_eff;
   logic [1:0]    wr_skip;
   logic [1:0]    wr_cnt;
   logic [PW-1:0] head_next_idx;
   logic [PW-1:0] tail_next_idx;

   assign stall     = (count > CW'(DEPTH - 2));
   assign occupancy = count;

   assign head_next_idx = head + PW'(1);
   assign tail_next_idx = tail + PW'(1);

   // Work out how many entries arrive, leave, and actually get written this cycle.
   always_comb begin
      enq         = 2'd0;
      deq         = 2'd0;
      consume_eff = (consume == 2'd3) ? 2'd2 : consume;
      wr_skip     = 2'd0;
      if (!stall && !flush && instructionA_valid)
         enq = instructionB_valid ? 2'd2 : 2'd1;
      if (CW'(consume_eff) > count)
         deq = count[1:0];
      else
         deq = consume_eff;
`ifdef IBUF_BYPASS_EN
      // Bypassed entries consumed by decode never occupy storage.
      if (count == '0 && !flush)
         wr_skip = (consume_eff > enq) ? enq : consume_eff;
`endif
      wr_cnt = enq - wr_skip;
   end

   // Pointer and count state; flush wins over any same-cycle traffic.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq);
         tail  <= tail + PW'(wr_cnt);
         count <= count + CW'(wr_cnt) - CW'(deq);
      end
   end

   // Storage is not reset; validity comes solely from count.
   always_ff @(posedge clk) begin
      if (!flush && wr_cnt != 2'd0) begin
         instr_mem[tail] <= (wr_skip == 2'd1) ? instructionB : instructionA;
         addr_mem[tail]  <= (wr_skip == 2'd1) ? addressB : addressA;
      end
      if (!flush && wr_cnt == 2'd2) begin
         instr_mem[tail_next_idx] <= instructionB;
         addr_mem[tail_next_idx]  <= addressB;
      end
   end

   always_comb begin
      issueA        = '0;
      issueB        = '0;
      issueAddressA = '0;
      issueAddressB = '0;
      issueA_valid  = 1'b0;
      issueB_valid  = 1'b0;
      if (count >= CW'(1)) begin
         issueA        = instr_mem[head];
         issueAddressA = addr_mem[head];
         issueA_valid  = 1'b1;
      end
      if (count >= CW'(2)) begin
         issueB        = instr_mem[head_next_idx];
         issueAddressB = addr_mem[head_next_idx];
         issueB_valid  = 1'b1;
      end
`ifdef IBUF_BYPASS_EN
      if (count == '0 && !flush && instructionA_valid) begin
         issueA        = instructionA;
         issueAddressA = addressA;
         issueA_valid  = 1'b1;
         if (instructionB_valid) begin
            issueB        = instructionB;
            issueAddressB = addressB;
            issueB_valid  = 1'b1;
         end
      end
`endif
   end

   bOnlyWithA : assert property (@(posedge clk) disable iff (!reset)
      !(instructionB_valid && !instructionA_valid));

endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer with a queue-based reference model checked every negedge.
// Honours IBUF_BYPASS_EN the same way the design does.
module tb_instruction_buffer;

   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] addr;
   } entry_t;

   logic            clk;
   logic            reset;
   logic            flush;
   logic [XLEN-1:0] instructionA;
   logic [XLEN-1:0] instructionB;
   logic [XLEN-1:0] addressA;
   logic [XLEN-1:0] addressB;
   logic            instructionA_valid;
   logic            instructionB_valid;
   logic            stall;
   logic [XLEN-1:0] issueA;
   logic [XLEN-1:0] issueB;
   logic [XLEN-1:0] issueAddressA;
   logic [XLEN-1:0] issueAddressB;
   logic            issueA_valid;
   logic            issueB_valid;
   logic [1:0]      consume;
   logic [3:0]      occupancy;

   int testsRun;
   int testsFailed;

   entry_t modelQ[$];
   entry_t incoming[$];
   entry_t view[$];

   instruction_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk                (clk),
      .reset              (reset),
      .flush              (flush),
      .instructionA       (instructionA),
      .instructionB       (instructionB),
      .addressA           (addressA),
      .addressB           (addressB),
      .instructionA_valid (instructionA_valid),
      .instructionB_valid (instructionB_valid),
      .stall              (stall),
      .issueA             (issueA),
      .issueB             (issueB),
      .issueAddressA      (issueAddressA),
      .issueAddressB      (issueAddressB),
      .issueA_valid       (issueA_valid),
      .issueB_valid       (issueB_valid),
      .consume            (consume),
      .occupancy          (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic bv,
                                input logic [XLEN-1:0] ia, input logic [XLEN-1:0] aa,
                                input logic [XLEN-1:0] ib, input logic [XLEN-1:0] ab,
                                input logic [1:0] cons, input logic fl);
      instructionA_valid = av;
      instructionB_valid = bv;
      instructionA       = ia;
      addressA           = aa;
      instructionB       = ib;
      addressB           = ab;
      consume            = cons;
      flush              = fl;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 2'd0, 1'b0);
   endtask

   function automatic logic [XLEN-1:0] seqInstr(input int n);
      return 32'h0000_1000 + XLEN'(n);
   endfunction

   function automatic logic [XLEN-1:0] seqAddr(input int n);
      return XLEN'(4 * n);
   endfunction

   task automatic pushPair(input int n, input logic [1:0] cons);
      applyStimulus(1'b1, 1'b1, seqInstr(n), seqAddr(n), seqInstr(n + 1), seqAddr(n + 1), cons, 1'b0);
      stepCycle();
   endtask

   task automatic pushOne(input int n, input logic [1:0] cons);
      applyStimulus(1'b1, 1'b0, seqInstr(n), seqAddr(n), '0, '0, cons, 1'b0);
      stepCycle();
   endtask

   // Reference model: a plain queue of entries in program order.
   always @(posedge clk or negedge reset) begin
      int c;
      int avail;
      if (!reset) begin
         modelQ.delete();
      end else if (flush) begin
         modelQ.delete();
      end else begin
         incoming.delete();
         if (modelQ.size() < DEPTH - 1 && instructionA_valid) begin
            incoming.push_back('{instructionA, addressA});
            if (instructionB_valid) incoming.push_back('{instructionB, addressB});
         end
         c = (consume == 2'd3) ? 2 : int'(consume);
         avail = modelQ.size();
`ifdef IBUF_BYPASS_EN
         if (modelQ.size() == 0) avail = incoming.size();
`endif
         if (c > avail) c = avail;
         foreach (incoming[i]) modelQ.push_back(incoming[i]);
         for (int k = 0; k < c; k++) void'(modelQ.pop_front());
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      entry_t ea;
      entry_t eb;
      view = modelQ;
`ifdef IBUF_BYPASS_EN
      if (modelQ.size() == 0 && !flush && instructionA_valid) begin
         view.push_back('{instructionA, addressA});
         if (instructionB_valid) view.push_back('{instructionB, addressB});
      end
`endif
      ea = (view.size() >= 1) ? view[0] : '0;
      eb = (view.size() >= 2) ? view[1] : '0;
      checkOutput("occupancy", XLEN'(occupancy), XLEN'(modelQ.size()));
      checkOutput("stall", XLEN'(stall), XLEN'(modelQ.size() > DEPTH - 2));
      checkOutput("issueA_valid", XLEN'(issueA_valid), XLEN'(view.size() >= 1));
      checkOutput("issueB_valid", XLEN'(issueB_valid), XLEN'(view.size() >= 2));
      checkOutput("issueA", issueA, ea.instr);
      checkOutput("issueAddressA", issueAddressA, ea.addr);
      checkOutput("issueB", issueB, eb.instr);
      checkOutput("issueAddressB", issueAddressB, eb.addr);
   end

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 2'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset occupancy", XLEN'(occupancy), 32'd0);
      checkOutput("reset stall", XLEN'(stall), 32'd0);
      checkOutput("reset issueA_valid", XLEN'(issueA_valid), 32'd0);
      checkOutput("reset issueA", issueA, 32'd0);
      reset = 1'b1;

      // First pair, then visible next cycle.
      applyStimulus(1'b1, 1'b1, 32'h0000_0013, 32'h0, 32'h0010_0093, 32'h4, 2'd0, 1'b0);
      stepCycle();
      checkOutput("first issueA", issueA, 32'h0000_0013);
      checkOutput("first issueAddressA", issueAddressA, 32'h0);
      checkOutput("first issueB", issueB, 32'h0010_0093);
      checkOutput("first issueAddressB", issueAddressB, 32'h4);
      checkOutput("first valids", XLEN'({issueA_valid, issueB_valid}), 32'd3);
      checkOutput("first occupancy", XLEN'(occupancy), 32'd2);

      // Fill to 7, drop a write under stall, then drain two.
      pushPair(2, 2'd0);
      pushPair(4, 2'd0);
      pushOne(6, 2'd0);
      checkOutput("full stall", XLEN'(stall), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h100, '0, '0, 2'd0, 1'b0);
      stepCycle();
      checkOutput("dropped occupancy", XLEN'(occupancy), 32'd7);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 2'd2, 1'b0);
      stepCycle();
      checkOutput("drain occupancy", XLEN'(occupancy), 32'd5);
      checkOutput("drain stall", XLEN'(stall), 32'd0);

      // tail is 7 here: this pair straddles the wrap.
      pushPair(8, 2'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 2'd2, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 2'd2, 1'b0);
      stepCycle();
      checkOutput("wrap issueA", issueA, seqInstr(6));
      checkOutput("wrap issueB", issueB, seqInstr(8));
      checkOutput("wrap occupancy", XLEN'(occupancy), 32'd3);

      // Simultaneous write 2 / consume 2 at occupancy 3.
      pushPair(10, 2'd2);
      checkOutput("concurrent occupancy", XLEN'(occupancy), 32'd3);
      checkOutput("concurrent issueA", issueA, seqInstr(9));
      checkOutput("concurrent issueAddressA", issueAddressA, 32'h24);

      // Flush at occupancy 6 with a write and a consume in flight.
      pushPair(12, 2'd0);
      pushOne(14, 2'd0);
      checkOutput("preflush occupancy", XLEN'(occupancy), 32'd6);
      applyStimulus(1'b1, 1'b1, seqInstr(16), seqAddr(16), seqInstr(17), seqAddr(17), 2'd1, 1'b1);
      stepCycle();
      checkOutput("flush occupancy", XLEN'(occupancy), 32'd0);
      checkOutput("flush valids", XLEN'({issueA_valid, issueB_valid}), 32'd0);
      checkOutput("flush stall", XLEN'(stall), 32'd0);

      // Same-cycle write and consume into an empty buffer.
      applyStimulus(1'b1, 1'b0, 32'h00A0_0113, 32'h20, '0, '0, 2'd1, 1'b0);
      @(negedge clk);
      #1;
`ifdef IBUF_BYPASS_EN
      checkOutput("bypass issueA", issueA, 32'h00A0_0113);
      checkOutput("bypass issueA_valid", XLEN'(issueA_valid), 32'd1);
`else
      checkOutput("nobypass issueA", issueA, 32'd0);
      checkOutput("nobypass issueA_valid", XLEN'(issueA_valid), 32'd0);
`endif
      stepCycle();
`ifdef IBUF_BYPASS_EN
      checkOutput("bypass occupancy", XLEN'(occupancy), 32'd0);
`else
      checkOutput("nobypass occupancy", XLEN'(occupancy), 32'd1);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 2'd1, 1'b0);
      stepCycle();
`endif

      // Two arrive at an empty buffer, decode takes one.
      applyStimulus(1'b1, 1'b1, 32'h2000, 32'h40, 32'h2004, 32'h44, 2'd1, 1'b0);
      stepCycle();
`ifdef IBUF_BYPASS_EN
      checkOutput("split occupancy", XLEN'(occupancy), 32'd1);
      checkOutput("split issueA", issueA, 32'h2004);
`else
      checkOutput("split occupancy", XLEN'(occupancy), 32'd2);
      checkOutput("split issueA", issueA, 32'h2000);
`endif

      // consume = 3 behaves as 2.
      pushPair(20, 2'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 2'd3, 1'b0);
      stepCycle();
`ifdef IBUF_BYPASS_EN
      checkOutput("consume3 occupancy", XLEN'(occupancy), 32'd1);
`else
      checkOutput("consume3 occupancy", XLEN'(occupancy), 32'd2);
`endif

      // Mixed traffic pattern, model-checked every cycle.
      for (int i = 0; i < 40; i++) begin
         logic av;
         logic bv;
         av = (i % 3) != 0;
         bv = av && ((i % 2) == 0);
         applyStimulus(av, bv, seqInstr(100 + 2 * i), seqAddr(100 + 2 * i),
                       seqInstr(101 + 2 * i), seqAddr(101 + 2 * i), 2'(i % 4), i == 25);
         stepCycle();
      end

      // Asynchronous reset in the middle of a cycle.
      pushPair(200, 2'd0);
      pushPair(202, 2'd0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async reset occupancy", XLEN'(occupancy), 32'd0);
      checkOutput("async reset issueA_valid", XLEN'(issueA_valid), 32'd0);
      checkOutput("async reset issueA", issueA, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      stepCycle();
      stepCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
